// File: rtl/shift_sequencer.sv
// shift_sequencer: serial shift controller.
// Accepts one command (operand, direction, amount, rotate) over a valid/ready
// handshake, shifts the internal register one bit per cycle the requested
// number of times, then presents the result over a second valid/ready
// handshake.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN. When it is defined, in_rotate
// selects rotate fill. When it is undefined, every shift is logical with zero
// fill. The port list is the same in both builds.
module shift_sequencer #(
  parameter int DATA_WIDTH = 4,
  parameter int AMT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_left,
  input  logic [AMT_WIDTH-1:0]  in_amt,
  input  logic                  in_rotate,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic [AMT_WIDTH-1:0]  shift_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AMT_WIDTH-1:0]  AMT_ZERO  = {AMT_WIDTH{1'b0}};
  localparam logic [AMT_WIDTH-1:0]  AMT_ONE   = {{(AMT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_t                state_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  left_r;
  logic [AMT_WIDTH-1:0]  count_r;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic                  busy_r;
  logic                  rotate_s;
  logic [DATA_WIDTH-1:0] shifted_s;

`ifdef SHIFT_SEQ_ROTATE_EN
  logic rotate_r;

  // Rotate mode comes from the flag latched at accept.
  always_comb begin
    rotate_s = rotate_r;
  end
`else
  // The rotate input is deliberately unused in the logical-only build.
  logic unused_rotate_s;
  assign unused_rotate_s = in_rotate;

  // Without rotate support every shift is logical.
  always_comb begin
    rotate_s = 1'b0;
  end
`endif

  // One-bit shift. The fill bit is the wrapped-around end bit when rotating,
  // and zero otherwise.
  function automatic logic [DATA_WIDTH-1:0] shift_once(
    input logic [DATA_WIDTH-1:0] d,
    input logic                  left,
    input logic                  rot
  );
    logic fill;
    if (rot) begin
      fill = left ? d[DATA_WIDTH-1] : d[0];
    end else begin
      fill = 1'b0;
    end
    if (left) begin
      return {d[DATA_WIDTH-2:0], fill};
    end else begin
      return {fill, d[DATA_WIDTH-1:1]};
    end
  endfunction

  // Next value of the shift register for the current direction and mode.
  always_comb begin
    shifted_s = shift_once(data_r, left_r, rotate_s);
  end

  // Sequencer FSM: state, datapath registers and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      data_r      <= DATA_ZERO;
      left_r      <= 1'b0;
      count_r     <= AMT_ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
      rotate_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            data_r     <= in_data;
            left_r     <= in_left;
            count_r    <= in_amt;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
            rotate_r   <= in_rotate;
`endif
            if (in_amt == AMT_ZERO) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
            end else begin
              state_r     <= SHIFT;
              out_valid_r <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          data_r  <= shifted_s;
          count_r <= count_r - AMT_ONE;
          if (count_r == AMT_ONE) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          // The result and the count hold until the consumer takes them.
          if (out_ready) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          data_r      <= DATA_ZERO;
          count_r     <= AMT_ZERO;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign out_data    = data_r;
  assign shift_count = count_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer. It drives directed commands and
// pushes each expected result and latency to a scoreboard queue. Entries are
// popped and compared when the DUT raises out_valid.
module tb_shift_sequencer;

  localparam int W = 4;
  localparam int A = 3;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_left;
  logic [A-1:0] in_amt;
  logic         in_rotate;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;
  logic [A-1:0] shift_count;

  typedef struct {
    logic [W-1:0] data;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;

  shift_sequencer #(.DATA_WIDTH(W), .AMT_WIDTH(A)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_left(in_left), .in_amt(in_amt), .in_rotate(in_rotate),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .shift_count(shift_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result built arithmetically rather than bit by bit.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic left,
                                         input logic rot, input int amt);
    logic [W-1:0] r;
    int           m;
    logic         rot_en;
`ifdef SHIFT_SEQ_ROTATE_EN
    rot_en = rot;
`else
    rot_en = 1'b0;
`endif
    if (rot_en) begin
      m = amt % W;
      if (m == 0) r = d;
      else if (left) r = (d << m) | (d >> (W - m));
      else r = (d >> m) | (d << (W - m));
    end else if (amt >= W) begin
      r = '0;
    end else if (left) begin
      r = d << amt;
    end else begin
      r = d >> amt;
    end
    return r;
  endfunction

  // Accept one command, wait for its result, compare it, then consume it.
  task automatic run_cmd(input string tag, input logic [W-1:0] d, input logic left,
                         input logic rot, input int amt);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid  = 1'b1;
    in_data   = d;
    in_left   = left;
    in_rotate = rot;
    in_amt    = amt[A-1:0];
    e.data    = model(d, left, rot, amt);
    e.lat     = amt;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_out_valid"}, out_valid, 1'b1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_latency"}, n, e.lat);
      check({tag, "_data"}, out_data, e.data);
    end else begin
      check({tag, "_scoreboard_empty"}, 1'b1, 1'b0);
    end
    check({tag, "_busy"}, busy, 1'b1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, in_ready, 1'b1);
    check({tag, "_idle_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    exp_t e;
    int   pulses;
    int   n;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'b1111;
    in_left   = 1'b1;
    in_amt    = 3'd0;
    in_rotate = 1'b0;
    out_ready = 1'b0;

    // Reset held for two edges with a command offered; it must not be taken.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, 4'b0000);
    check("rst_shift_count", shift_count, 3'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 1'b0);

    run_cmd("left1", 4'b1010, 1'b1, 1'b0, 1);
    run_cmd("right2", 4'b1100, 1'b0, 1'b0, 2);
    run_cmd("zero", 4'b1010, 1'b1, 1'b0, 0);
    run_cmd("over7", 4'b1111, 1'b1, 1'b0, 7);
    run_cmd("right3", 4'b1001, 1'b0, 1'b0, 3);

    // Backpressure: the result holds while out_ready is low and new commands are ignored.
    in_valid = 1'b1;
    in_data  = 4'b0110;
    in_left  = 1'b0;
    in_amt   = 3'd1;
    e.data   = model(4'b0110, 1'b0, 1'b0, 1);
    e.lat    = 1;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_data = 4'b1111;
    in_amt  = 3'd0;
    in_left = 1'b1;
    @(negedge clk);
    e = sb_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_data", out_data, e.data);
      check("bp_shift_count", shift_count, 3'd0);
      check("bp_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_ready", in_ready, 1'b1);
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_data", out_data, 4'b0011);

    run_cmd("rot_l1", 4'b1010, 1'b1, 1'b1, 1);
    run_cmd("rot_r1", 4'b0011, 1'b0, 1'b1, 1);
    run_cmd("rot_r5", 4'b0011, 1'b0, 1'b1, 5);

    // Reset during SHIFT aborts the command without any out_valid pulse.
    pulses   = 0;
    in_valid = 1'b1;
    in_data  = 4'b0011;
    in_left  = 1'b1;
    in_amt   = 3'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (out_valid) pulses++;
    @(negedge clk);
    if (out_valid) pulses++;
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_in_ready", in_ready, 1'b1);
    check("mid_out_data", out_data, 4'b0000);
    check("mid_busy_clear", busy, 1'b0);
    check("mid_count", shift_count, 3'd0);
    n = 0;
    while (n < 6) begin
      if (out_valid) pulses++;
      @(negedge clk);
      n++;
    end
    check("mid_no_pulse", pulses, 0);
    run_cmd("after_rst", 4'b0011, 1'b0, 1'b0, 1);

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
